// File: rtl/alarm_ring_ctrl_if.sv
// ----------------------------------------------------------------------------
// alarm_ring_ctrl_if
//   Groups the alarm sequencer's control inputs and status outputs into a
//   single bundle.
//   master : drives the controls (time/alarm logic, buttons, tick source)
//            and observes the status
//   slave  : the alarm_ring_ctrl sequencer itself
//   Signals:
//     i_tick        1 Hz tick, one clk cycle wide
//     i_match       level, current time equals alarm time
//     i_alarm_en    level, alarm armed
//     i_snooze      snooze button pulse
//     i_stop        stop button pulse
//     o_buzz_en     buzzer enable
//     o_state       sequencer state code
//     o_snooze_cnt  snoozes used in this alarm event
//     o_sec_cnt     seconds elapsed in the current RING/SNOOZE phase
// ----------------------------------------------------------------------------
interface alarm_ring_ctrl_if;
  logic       i_tick;
  logic       i_match;
  logic       i_alarm_en;
  logic       i_snooze;
  logic       i_stop;
  logic       o_buzz_en;
  logic [1:0] o_state;
  logic [2:0] o_snooze_cnt;
  logic [8:0] o_sec_cnt;

  modport master (
    output i_tick, i_match, i_alarm_en, i_snooze, i_stop,
    input  o_buzz_en, o_state, o_snooze_cnt, o_sec_cnt
  );

  modport slave (
    input  i_tick, i_match, i_alarm_en, i_snooze, i_stop,
    output o_buzz_en, o_state, o_snooze_cnt, o_sec_cnt
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// ----------------------------------------------------------------------------
// alarm_ring_ctrl
//   Alarm buzzer sequencer for the digital clock. Detects the rising edge of
//   the alarm-time match, rings the buzzer, handles snooze and stop buttons
//   and times out automatically. All timing comes from a one-cycle 1 Hz tick.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    alarm_ring_ctrl_if.slave (controls in, status out)
//   Parameters:
//     RING_SEC    seconds of ringing before auto-timeout (1..511)
//     SNOOZE_SEC  seconds of silence per snooze (1..511)
//     MAX_SNOOZE  snoozes allowed per alarm event (0..7)
// ----------------------------------------------------------------------------
module alarm_ring_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input logic            clk,
  input logic            rst_n,
  alarm_ring_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam logic [8:0] RING_LAST   = 9'(RING_SEC - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SEC - 1);
  localparam logic [2:0] MAX_SNZ     = 3'(MAX_SNOOZE);

  state_t     state_q, state_d;
  logic [8:0] sec_cnt_q, sec_cnt_d;
  logic [2:0] snooze_cnt_q, snooze_cnt_d;
  logic       match_dly_q, match_dly_d;

  logic match_rise;
  logic snooze_left;

  assign match_rise  = bus.i_match & ~match_dly_q;
  assign snooze_left = (snooze_cnt_q < MAX_SNZ);
  assign match_dly_d = bus.i_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sec_cnt_q    <= '0;
      snooze_cnt_q <= '0;
      match_dly_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      match_dly_q  <= match_dly_d;
    end
  end

  // A button that causes a transition consumes any tick in the same cycle,
  // so ticks are only examined in the branches where no button acted.
  // A snooze refused because the limit is reached is not a transition, so a
  // coincident tick still counts.
  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    snooze_cnt_d = snooze_cnt_q;

    if (!bus.i_alarm_en) begin
      state_d      = ST_IDLE;
      sec_cnt_d    = '0;
      snooze_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sec_cnt_d    = '0;
          snooze_cnt_d = '0;
          if (match_rise) begin
            state_d = ST_RING;
          end
        end

        ST_RING: begin
          if (bus.i_stop) begin
            state_d   = ST_DONE;
            sec_cnt_d = '0;
          end else if (bus.i_snooze && snooze_left) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 3'd1;
            sec_cnt_d    = '0;
          end else if (bus.i_tick) begin
            if (sec_cnt_q == RING_LAST) begin
              sec_cnt_d = '0;
              if (snooze_left) begin
                state_d      = ST_SNOOZE;
                snooze_cnt_d = snooze_cnt_q + 3'd1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              sec_cnt_d = sec_cnt_q + 9'd1;
            end
          end
        end

        ST_SNOOZE: begin
          if (bus.i_stop) begin
            state_d   = ST_DONE;
            sec_cnt_d = '0;
          end else if (bus.i_tick) begin
            if (sec_cnt_q == SNOOZE_LAST) begin
              state_d   = ST_RING;
              sec_cnt_d = '0;
            end else begin
              sec_cnt_d = sec_cnt_q + 9'd1;
            end
          end
        end

        ST_DONE: begin
          // Held until the match level drops so the same match second
          // cannot re-trigger; the snooze count is cleared on the way out
          // so IDLE always shows zero.
          sec_cnt_d = '0;
          if (!bus.i_match) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = '0;
          end
        end

        default: begin
          state_d      = ST_IDLE;
          sec_cnt_d    = '0;
          snooze_cnt_d = '0;
        end
      endcase
    end
  end

  assign bus.o_state      = state_q;
  assign bus.o_buzz_en    = (state_q == ST_RING);
  assign bus.o_snooze_cnt = snooze_cnt_q;
  assign bus.o_sec_cnt    = sec_cnt_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alarm_ring_ctrl
//   Directed bench for alarm_ring_ctrl with RING_SEC=3, SNOOZE_SEC=5,
//   MAX_SNOOZE=2. Outputs are packed as {state, buzz, snooze_cnt, sec_cnt}
//   and compared against hand-computed values one cycle-step at a time.
// ----------------------------------------------------------------------------
module tb_alarm_ring_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [14:0] exp_v;
  logic [14:0] obs;

  alarm_ring_ctrl_if bus ();

  alarm_ring_ctrl #(
    .RING_SEC   (3),
    .SNOOZE_SEC (5),
    .MAX_SNOOZE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign obs = {bus.o_state, bus.o_buzz_en, bus.o_snooze_cnt, bus.o_sec_cnt};

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against any unexpected stall of the sequence below
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [14:0] pk(input logic [1:0] st, input logic bz,
                                     input int sn, input int sec);
    return {st, bz, 3'(sn), 9'(sec)};
  endfunction

  // Advance past the next rising edge; outputs are stable 1 ns later
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic t, input logic s, input logic p);
    bus.i_tick   = t;
    bus.i_snooze = s;
    bus.i_stop   = p;
    cycle();
    bus.i_tick   = 1'b0;
    bus.i_snooze = 1'b0;
    bus.i_stop   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle();
    cycle();
    exp_v = pk(2'b00, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %b expected %b", obs, exp_v);
    end
    rst_n = 1'b1;
    bus.i_alarm_en = 1'b1;
    cycle();
    bus.i_match = 1'b1;
    cycle();
    ticks(1);
    exp_v = pk(2'b01, 1'b1, 0, 1);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_ring: got %b expected %b", obs, exp_v);
    end
    // Assert reset between edges: outputs must clear without a clock
    rst_n = 1'b0;
    #2;
    exp_v = pk(2'b00, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %b expected %b", obs, exp_v);
    end
    bus.i_match    = 1'b0;
    bus.i_alarm_en = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_ring_and_snooze();
    bus.i_alarm_en = 1'b1;
    cycle();
    bus.i_match = 1'b1;
    cycle();
    exp_v = pk(2'b01, 1'b1, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL ring_entry: got %b expected %b", obs, exp_v);
    end
    ticks(2);
    cycle();
    exp_v = pk(2'b01, 1'b1, 0, 2);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL ring_count: got %b expected %b", obs, exp_v);
    end
    ticks(1);
    exp_v = pk(2'b10, 1'b0, 1, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL ring_timeout_snooze: got %b expected %b", obs, exp_v);
    end
    ticks(4);
    exp_v = pk(2'b10, 1'b0, 1, 4);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL snooze_count: got %b expected %b", obs, exp_v);
    end
    ticks(1);
    exp_v = pk(2'b01, 1'b1, 1, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL snooze_rering: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_snooze_limit();
    pulse(1'b0, 1'b1, 1'b0);
    exp_v = pk(2'b10, 1'b0, 2, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL second_snooze: got %b expected %b", obs, exp_v);
    end
    ticks(5);
    pulse(1'b0, 1'b1, 1'b0);
    exp_v = pk(2'b01, 1'b1, 2, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL snooze_ignored: got %b expected %b", obs, exp_v);
    end
    ticks(3);
    exp_v = pk(2'b11, 1'b0, 2, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL final_timeout_done: got %b expected %b", obs, exp_v);
    end
    bus.i_match = 1'b0;
    cycle();
    exp_v = pk(2'b00, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL done_to_idle: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_stop_priority();
    bus.i_match = 1'b1;
    cycle();
    pulse(1'b0, 1'b1, 1'b1);
    exp_v = pk(2'b11, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL stop_beats_snooze: got %b expected %b", obs, exp_v);
    end
    cycle();
    cycle();
    exp_v = pk(2'b11, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL done_holds: got %b expected %b", obs, exp_v);
    end
    bus.i_match = 1'b0;
    cycle();
    exp_v = pk(2'b00, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL done_release: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_arm_and_disable();
    bus.i_alarm_en = 1'b0;
    bus.i_match    = 1'b1;
    cycle();
    cycle();
    bus.i_alarm_en = 1'b1;
    cycle();
    cycle();
    cycle();
    exp_v = pk(2'b00, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL armed_on_match: got %b expected %b", obs, exp_v);
    end
    bus.i_match = 1'b0;
    cycle();
    bus.i_match = 1'b1;
    cycle();
    ticks(3);
    exp_v = pk(2'b10, 1'b0, 1, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL pre_disable_snooze: got %b expected %b", obs, exp_v);
    end
    ticks(2);
    bus.i_alarm_en = 1'b0;
    cycle();
    exp_v = pk(2'b00, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL disable_in_snooze: got %b expected %b", obs, exp_v);
    end
    bus.i_match    = 1'b0;
    bus.i_alarm_en = 1'b1;
    cycle();
  endtask

  task automatic test_tick_coincident();
    bus.i_match = 1'b1;
    cycle();
    ticks(2);
    exp_v = pk(2'b01, 1'b1, 0, 2);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL coincide_setup: got %b expected %b", obs, exp_v);
    end
    pulse(1'b1, 1'b1, 1'b0);
    exp_v = pk(2'b10, 1'b0, 1, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL tick_with_snooze: got %b expected %b", obs, exp_v);
    end
    ticks(1);
    pulse(1'b0, 1'b1, 1'b0);
    exp_v = pk(2'b10, 1'b0, 1, 1);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL snooze_in_snooze: got %b expected %b", obs, exp_v);
    end
    pulse(1'b1, 1'b0, 1'b1);
    exp_v = pk(2'b11, 1'b0, 1, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL stop_in_snooze: got %b expected %b", obs, exp_v);
    end
    bus.i_match = 1'b0;
    cycle();
    exp_v = pk(2'b00, 1'b0, 0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL final_idle: got %b expected %b", obs, exp_v);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.i_tick     = 1'b0;
    bus.i_match    = 1'b0;
    bus.i_alarm_en = 1'b0;
    bus.i_snooze   = 1'b0;
    bus.i_stop     = 1'b0;

    test_reset();
    test_ring_and_snooze();
    test_snooze_limit();
    test_stop_priority();
    test_arm_and_disable();
    test_tick_coincident();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
